// File: rtl/tone_nco_pkg.sv
// tone_nco_pkg: shared types and constants for the tone_nco audio tone generator.
//   env_state_e : envelope state encoding (IDLE, ATTACK, SUSTAIN, RELEASE)
//   DEF_*       : default parameter values for the generator
//   env_max()   : largest positive envelope value for a given signed sample width
package tone_nco_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ATTACK  = 2'd1,
    SUSTAIN = 2'd2,
    RELEASE = 2'd3
  } env_state_e;

  localparam int DEF_WIDTH      = 32;
  localparam int DEF_AMP_WIDTH  = 16;
  localparam int DEF_SAMPLE_DIV = 256;
  localparam int DEF_RAMP_STEP  = 64;

  function automatic int env_max(input int amp_width);
    return (1 << (amp_width - 1)) - 1;
  endfunction

endpackage

// File: rtl/tone_nco_env.sv
// tone_nco_env: linear attack/sustain/release envelope with a saturating level.
// All state changes happen on tick_i only.
// Ports:
//   clk_i, reset_i   clock, synchronous active-low reset
//   tick_i           sample tick
//   note_on_i        frequency step (as it will be after this tick) is non-zero
//   retrig_i         pending note-boundary request
//   env_nxt_o        envelope level after this cycle's update
//   state_o          registered envelope state (env_state_e encoding)
//   phase_clr_o      phase accumulator must be forced to zero on this tick
module tone_nco_env import tone_nco_pkg::*; #(
  parameter int amp_width_p = DEF_AMP_WIDTH,
  parameter int ramp_step_p = DEF_RAMP_STEP
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   tick_i,
  input  logic                   note_on_i,
  input  logic                   retrig_i,
  output logic [amp_width_p-1:0] env_nxt_o,
  output logic [1:0]             state_o,
  output logic                   phase_clr_o
);

  localparam int AW = amp_width_p;
  localparam logic [AW:0] STEP = (AW+1)'(ramp_step_p);
  localparam logic [AW:0] EMAX = (AW+1)'(env_max(AW));

  localparam logic [1:0] ST_IDLE    = IDLE;
  localparam logic [1:0] ST_ATTACK  = ATTACK;
  localparam logic [1:0] ST_SUSTAIN = SUSTAIN;
  localparam logic [1:0] ST_RELEASE = RELEASE;

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] env_q, env_d;
  logic          clr;

  function automatic logic [AW-1:0] sat_inc(input logic [AW-1:0] e);
    logic [AW:0] s;
    s = {1'b0, e} + STEP;
    return (s > EMAX) ? EMAX[AW-1:0] : s[AW-1:0];
  endfunction

  function automatic logic [AW-1:0] sat_dec(input logic [AW-1:0] e);
    logic [AW:0] s;
    s = {1'b0, e} - STEP;
    return ({1'b0, e} <= STEP) ? '0 : s[AW-1:0];
  endfunction

  always_comb begin
    state_d = state_q;
    env_d   = env_q;
    clr     = 1'b0;
    if (tick_i) begin
      case (state_q)
        ST_IDLE: begin
          if (note_on_i) begin
            state_d = ST_ATTACK;
            env_d   = sat_inc('0);
          end else begin
            env_d = '0;
            clr   = 1'b1;
          end
        end
        ST_ATTACK: begin
          // Leaving attack holds the level for this tick; decay begins next tick.
          if (!note_on_i || retrig_i) begin
            state_d = ST_RELEASE;
          end else begin
            env_d = sat_inc(env_q);
            if ({1'b0, env_d} == EMAX) state_d = ST_SUSTAIN;
          end
        end
        ST_SUSTAIN: begin
          if (!note_on_i || retrig_i) begin
            state_d = ST_RELEASE;
            env_d   = sat_dec(env_q);
          end
        end
        default: begin
          // RELEASE: a still-active note restarts from phase 0 once the level hits 0.
          if ({1'b0, env_q} <= STEP) begin
            env_d   = '0;
            clr     = 1'b1;
            state_d = note_on_i ? ST_ATTACK : ST_IDLE;
          end else begin
            env_d = sat_dec(env_q);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q <= ST_IDLE;
      env_q   <= '0;
    end else begin
      state_q <= state_d;
      env_q   <= env_d;
    end
  end

  assign env_nxt_o   = env_d;
  assign state_o     = state_q;
  assign phase_clr_o = clr;

endmodule

// File: rtl/tone_nco.sv
// tone_nco: NCO tone generator with ASR envelope and a valid/ready sample output.
// A phase accumulator advanced by fstep_i once per sample tick drives a square
// wave whose amplitude follows the envelope; one sample is offered per tick.
// Build option: define TONE_NCO_TRIANGLE_EN for a triangle waveform (adds one
// pipeline register, sample appears two cycles after the tick).
// Ports:
//   clk_i, reset_i  clock, synchronous active-low reset
//   fstep_i         phase increment per sample (0 = note off), sampled on tick
//   second_i        one-cycle note-boundary pulse (release / retrigger)
//   sample_o        signed PCM sample
//   valid_o         sample_o holds an unconsumed sample
//   ready_i         downstream accepts when valid_o & ready_i
//   busy_o          envelope is not IDLE
//   overrun_o       one-cycle pulse: an unconsumed sample was overwritten
module tone_nco import tone_nco_pkg::*; #(
  parameter int width_p      = DEF_WIDTH,
  parameter int amp_width_p  = DEF_AMP_WIDTH,
  parameter int sample_div_p = DEF_SAMPLE_DIV,
  parameter int ramp_step_p  = DEF_RAMP_STEP
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [width_p-1:0]     fstep_i,
  input  logic                   second_i,
  output logic [amp_width_p-1:0] sample_o,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic                   busy_o,
  output logic                   overrun_o
);

  localparam int AW = amp_width_p;
  localparam int CW = (sample_div_p > 1) ? $clog2(sample_div_p) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(sample_div_p - 1);

  logic [CW-1:0]      cnt_q, cnt_d;
  logic               tick;
  logic [width_p-1:0] fstep_q, fstep_d;
  logic [width_p-1:0] phase_q, phase_d;
  logic               retrig_q, retrig_d;
  logic [AW-1:0]      env_nxt;
  logic [1:0]         env_state;
  logic               phase_clr;
  logic               load;
  logic signed [AW-1:0] load_val;
  logic [AW-1:0]      sample_q, sample_d;
  logic               valid_q, valid_d;
  logic               overrun_q, overrun_d;

  assign tick  = (cnt_q == CNT_LAST);
  assign cnt_d = tick ? '0 : cnt_q + CW'(1);

  assign fstep_d  = tick ? fstep_i : fstep_q;
  // A pending request is consumed by whichever tick comes next.
  assign retrig_d = second_i | (retrig_q & ~tick);

  tone_nco_env #(
    .amp_width_p (amp_width_p),
    .ramp_step_p (ramp_step_p)
  ) u_env (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .tick_i      (tick),
    .note_on_i   (fstep_d != '0),
    .retrig_i    (retrig_q),
    .env_nxt_o   (env_nxt),
    .state_o     (env_state),
    .phase_clr_o (phase_clr)
  );

  assign phase_d = !tick    ? phase_q :
                   phase_clr ? '0 : phase_q + fstep_d;

`ifdef TONE_NCO_TRIANGLE_EN
  localparam logic signed [AW+1:0] SMAX = (AW+2)'(env_max(AW));
  localparam logic signed [AW+1:0] SMIN = ~SMAX;

  logic          tick_p1_q;
  logic [AW-1:0] env_p1_q;

  function automatic logic signed [AW-1:0] sat_s(input logic signed [AW+1:0] v);
    if (v > SMAX) return SMAX[AW-1:0];
    if (v < SMIN) return SMIN[AW-1:0];
    return v[AW-1:0];
  endfunction

  // Fold the phase into a ramp up/down, scale by env, then centre on zero.
  function automatic logic signed [AW-1:0] tri_map(input logic [width_p-1:0] ph,
                                                   input logic [AW-1:0] env);
    logic [AW-2:0]        t;
    logic [2*AW-2:0]      prod;
    logic signed [AW+1:0] v;
    t    = ph[width_p-1] ? ~ph[width_p-2 -: AW-1] : ph[width_p-2 -: AW-1];
    prod = {{AW{1'b0}}, t} * {{(AW-1){1'b0}}, env};
    v    = signed'({2'b00, prod[AW-1 +: AW]}) - signed'({3'b000, env[AW-1:1]});
    return sat_s(v);
  endfunction

  // Stage p1: post-tick phase/env are registered, waveform computed from them.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      tick_p1_q <= 1'b0;
      env_p1_q  <= '0;
    end else begin
      tick_p1_q <= tick;
      if (tick) env_p1_q <= env_nxt;
    end
  end

  assign load     = tick_p1_q;
  assign load_val = tri_map(phase_q, env_p1_q);
`else
  function automatic logic signed [AW-1:0] square_map(input logic msb,
                                                      input logic [AW-1:0] env);
    logic signed [AW-1:0] mag;
    mag = signed'(env);
    return msb ? -mag : mag;
  endfunction

  assign load     = tick;
  assign load_val = square_map(phase_d[width_p-1], env_nxt);
`endif

  // Output skid register: the latest sample always wins.
  assign sample_d  = load ? load_val : sample_q;
  assign valid_d   = load | (valid_q & ~ready_i);
  assign overrun_d = load & valid_q & ~ready_i;

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      cnt_q     <= '0;
      fstep_q   <= '0;
      phase_q   <= '0;
      retrig_q  <= 1'b0;
      sample_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      fstep_q   <= fstep_d;
      phase_q   <= phase_d;
      retrig_q  <= retrig_d;
      sample_q  <= sample_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign sample_o  = sample_q;
  assign valid_o   = valid_q;
  assign overrun_o = overrun_q;
  assign busy_o    = (env_state_e'(env_state) != IDLE);

endmodule

// File: tb/tb_tone_nco.sv
module tb_tone_nco;

  localparam int DIV  = 4;
  localparam int STEP = 8192;
  localparam int EMAX = 32767;
  localparam int M_IDLE = 0, M_ATK = 1, M_SUS = 2, M_REL = 3;

  logic        clk = 1'b0;
  logic        reset_i = 1'b0;
  logic [31:0] fstep_i = '0;
  logic        second_i = 1'b0;
  logic        ready_i = 1'b1;
  logic [15:0] sample_o;
  logic        valid_o, busy_o, overrun_o;

  always #5 clk = ~clk;

  tone_nco #(
    .width_p      (32),
    .amp_width_p  (16),
    .sample_div_p (DIV),
    .ramp_step_p  (STEP)
  ) dut (
    .clk_i     (clk),
    .reset_i   (reset_i),
    .fstep_i   (fstep_i),
    .second_i  (second_i),
    .sample_o  (sample_o),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .busy_o    (busy_o),
    .overrun_o (overrun_o)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state: sample-period position, envelope, phase, output slot.
  int        m_cnt = 0, m_st = M_IDLE, m_env = 0, m_sample = 0;
  bit [31:0] m_phase = '0;
  bit        m_retrig = 0, m_valid = 0, m_ovr = 0, m_ticked = 0;

  task automatic check(input string tag, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Advance the model by one clock using the inputs present at the coming edge.
  task automatic model_edge();
    bit tick, on, r, ovr;
    bit [31:0] f;
    if (!reset_i) begin
      m_cnt = 0; m_st = M_IDLE; m_env = 0; m_phase = '0; m_retrig = 0;
      m_valid = 0; m_sample = 0; m_ovr = 0; m_ticked = 0;
      return;
    end
    tick = (m_cnt == DIV - 1);
    m_cnt = (m_cnt + 1) % DIV;
    m_ticked = tick;
    ovr = tick && m_valid && !ready_i;
    r = m_retrig;
    if (tick) begin
      f  = fstep_i;
      on = (f != 0);
      case (m_st)
        M_IDLE: begin
          if (on) begin m_st = M_ATK; m_env = imin(STEP, EMAX); m_phase = f; end
          else begin m_env = 0; m_phase = '0; end
        end
        M_ATK: begin
          if (!on || r) m_st = M_REL;
          else begin
            m_env = imin(m_env + STEP, EMAX);
            if (m_env == EMAX) m_st = M_SUS;
          end
          m_phase = m_phase + f;
        end
        M_SUS: begin
          if (!on || r) begin
            m_st = M_REL;
            m_env = (m_env > STEP) ? m_env - STEP : 0;
          end
          m_phase = m_phase + f;
        end
        default: begin
          if (m_env <= STEP) begin
            m_env = 0; m_phase = '0;
            m_st = on ? M_ATK : M_IDLE;
          end else begin
            m_env = m_env - STEP;
            m_phase = m_phase + f;
          end
        end
      endcase
      m_sample = m_phase[31] ? -m_env : m_env;
      m_valid = 1;
    end else if (ready_i) begin
      m_valid = 0;
    end
    m_ovr = ovr;
    m_retrig = second_i || (m_retrig && !tick);
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check("valid", valid_o, m_valid);
    check("sample", $signed(sample_o), m_sample);
    check("overrun", overrun_o, m_ovr);
    check("busy", busy_o, (m_st != M_IDLE));
  endtask

  task automatic to_tick();
    for (int i = 0; i < 2 * DIV; i++) begin
      step();
      if (m_ticked) return;
    end
    check("tick_timeout", m_ticked, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int atk[4];
    int rel[4];
    int retr[8];
    atk  = '{8192, -16384, -24576, 32767};
    rel  = '{24575, 16383, 8191, 0};
    retr = '{24575, -16383, -8191, 0, 8192, -16384, -24576, 32767};

    // Reset state and idle zero stream
    reset_i = 1'b0; fstep_i = '0;
    step(); step();
    check("rst_valid", valid_o, 0);
    check("rst_sample", $signed(sample_o), 0);
    check("rst_busy", busy_o, 0);
    check("rst_overrun", overrun_o, 0);
    reset_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      to_tick();
      check("idle_valid", valid_o, 1);
      check("idle_sample", $signed(sample_o), 0);
      check("idle_busy", busy_o, 0);
    end

    // Attack from reset release
    reset_i = 1'b0; fstep_i = 32'h4000_0000;
    step(); step();
    reset_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      to_tick();
      check($sformatf("attack%0d", i), $signed(sample_o), atk[i]);
      check("attack_busy", busy_o, 1);
    end

    // Release to idle
    fstep_i = '0;
    for (int i = 0; i < 4; i++) begin
      to_tick();
      check($sformatf("release%0d", i), $signed(sample_o), rel[i]);
      check($sformatf("release_busy%0d", i), busy_o, (i < 3));
    end

    // Retrigger from sustain
    fstep_i = 32'h4000_0000;
    for (int i = 0; i < 4; i++) begin
      to_tick();
      check($sformatf("reattack%0d", i), $signed(sample_o), atk[i]);
    end
    second_i = 1'b1; step(); second_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      to_tick();
      check($sformatf("retrig%0d", i), $signed(sample_o), retr[i]);
    end

    // Backpressure across two loads
    step();
    ready_i = 1'b0;
    to_tick();
    check("bp_first_overrun", overrun_o, 0);
    check("bp_first_valid", valid_o, 1);
    to_tick();
    check("bp_overrun", overrun_o, 1);
    check("bp_newest", $signed(sample_o), -32767);
    step();
    check("bp_overrun_clear", overrun_o, 0);
    check("bp_still_valid", valid_o, 1);
    ready_i = 1'b1;
    step();
    check("bp_drained", valid_o, 0);

    // Mid-note reset during attack
    reset_i = 1'b0; step(); reset_i = 1'b1;
    to_tick(); to_tick();
    check("mid_attack", $signed(sample_o), -16384);
    reset_i = 1'b0; step();
    check("mid_valid", valid_o, 0);
    check("mid_busy", busy_o, 0);
    check("mid_sample", $signed(sample_o), 0);
    reset_i = 1'b1;
    to_tick();
    check("mid_restart", $signed(sample_o), 8192);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 49) == 0) begin
        case ($urandom_range(0, 3))
          0: fstep_i = '0;
          1: fstep_i = 32'h4000_0000;
          2: fstep_i = $urandom;
          default: fstep_i = $urandom_range(1, 1 << 20);
        endcase
      end
      second_i = ($urandom_range(0, 29) == 0);
      ready_i  = ($urandom_range(0, 3) != 0);
      reset_i  = ($urandom_range(0, 499) != 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
